add_align_unpack: RTL and testbench

ADD_ALIGN_UNPACK -- requirements
Module: add_align_unpack

---
 rtl/fpu_pkg.sv | 15 +
 rtl/add_align_unpack_if.sv | 32 +++
 rtl/right_shift_sticky.sv | 24 ++
 rtl/add_align_unpack.sv | 124 ++++++++++++
 tb/tb_add_align_unpack.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared single-precision field widths and packed operand type
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FRAC_W = 26;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/add_align_unpack_if.sv
// rtl/add_align_unpack_if.sv - operand input and aligned-result output handshake bundle
interface add_align_unpack_if;
  import fpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              sub;
  logic [2:0]        frm;
  logic              out_valid;
  logic              out_ready;
  logic              sign_l;
  logic              sign_s;
  logic [FRAC_W-1:0] frac_l;
  logic [FRAC_W-1:0] frac_s;
  logic [EXP_W-1:0]  exp_max;
  logic              inv;
  logic              ovf;
  logic [2:0]        frm_out;

  modport slave (
    input  in_valid, op_a, op_b, sub, frm, out_ready,
    output in_ready, out_valid, sign_l, sign_s, frac_l, frac_s, exp_max, inv, ovf, frm_out
  );

  modport master (
    output in_valid, op_a, op_b, sub, frm, out_ready,
    input  in_ready, out_valid, sign_l, sign_s, frac_l, frac_s, exp_max, inv, ovf, frm_out
  );

endinterface

// File: rtl/right_shift_sticky.sv
// rtl/right_shift_sticky.sv - right shift of a 26-bit fraction collapsing lost bits into bit 0
module right_shift_sticky
  import fpu_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic [EXP_W-1:0]  amt,
  output logic [FRAC_W-1:0] shifted
);

  logic [2*FRAC_W-1:0] ext;

  always_comb begin
    ext     = '0;
    shifted = '0;
    if (amt >= EXP_W'(FRAC_W)) begin
      shifted = {{(FRAC_W-1){1'b0}}, |frac};
    end else begin
      // Upper half holds the kept bits, lower half everything shifted out.
      ext     = {frac, {FRAC_W{1'b0}}} >> amt;
      shifted = {ext[2*FRAC_W-1:FRAC_W+1], ext[FRAC_W] | (|ext[FRAC_W-1:0])};
    end
  end

endmodule

// File: rtl/add_align_unpack.sv
// rtl/add_align_unpack.sv - fp32 adder front end: unpack, classify, order and align operands
module add_align_unpack
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  add_align_unpack_if.slave bus
);

  fp32_t            a, b;
  logic             sa, sb;
  logic [MAN_W:0]   ma, mb;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic             a_big, c_inv, c_ovf;
  logic [EXP_W-1:0] exp_l, exp_s;

  logic              s1_full, s2_full;
  logic              s1_adv, accept;
  logic              s1_sign_l, s1_sign_s, s1_inv, s1_ovf;
  logic [EXP_W-1:0]  s1_exp, s1_shamt;
  logic [FRAC_W-1:0] s1_frac_l, s1_frac_s, sh_out;
  logic [2:0]        s1_frm;

  logic              s2_sign_l, s2_sign_s, s2_inv, s2_ovf;
  logic [EXP_W-1:0]  s2_exp;
  logic [FRAC_W-1:0] s2_frac_l, s2_frac_s;
  logic [2:0]        s2_frm;

  assign a  = bus.op_a;
  assign b  = bus.op_b;
  assign sa = a.sign;
  assign sb = b.sign ^ bus.sub;

  // Zero exponent flushes denormals to signed zero; the hidden bit is set only for normals.
  assign ma = (a.exp == '0) ? '0 : {a.exp != EXP_INF, a.man};
  assign mb = (b.exp == '0) ? '0 : {b.exp != EXP_INF, b.man};

  assign nan_a = (a.exp == EXP_INF) && (a.man != '0);
  assign nan_b = (b.exp == EXP_INF) && (b.man != '0);
  assign inf_a = (a.exp == EXP_INF) && (a.man == '0);
  assign inf_b = (b.exp == EXP_INF) && (b.man == '0);

  // Ties go to op_a, which also makes a double-inf result take op_a's sign.
  assign a_big = (a.exp > b.exp) || ((a.exp == b.exp) && (ma >= mb));
  assign c_inv = nan_a | nan_b | (inf_a & inf_b & (sa != sb));
  assign c_ovf = ~c_inv & (inf_a | inf_b);
  assign exp_l = a_big ? a.exp : b.exp;
  assign exp_s = a_big ? b.exp : a.exp;

  assign s1_adv       = ~s2_full | bus.out_ready;
  assign bus.in_ready = ~s1_full | s1_adv;
  assign accept       = bus.in_valid & bus.in_ready;

  right_shift_sticky u_align (
    .frac    (s1_frac_s),
    .amt     (s1_shamt),
    .shifted (sh_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_full   <= 1'b0;
      s1_sign_l <= 1'b0;
      s1_sign_s <= 1'b0;
      s1_inv    <= 1'b0;
      s1_ovf    <= 1'b0;
      s1_exp    <= '0;
      s1_shamt  <= '0;
      s1_frac_l <= '0;
      s1_frac_s <= '0;
      s1_frm    <= '0;
    end else if (bus.in_ready) begin
      s1_full <= bus.in_valid;
      if (accept) begin
        s1_sign_l <= a_big ? sa : sb;
        s1_sign_s <= a_big ? sb : sa;
        s1_inv    <= c_inv;
        s1_ovf    <= c_ovf;
        s1_exp    <= exp_l;
        s1_shamt  <= exp_l - exp_s;
        s1_frac_l <= {(a_big ? ma : mb), 2'b00};
        s1_frac_s <= {(a_big ? mb : ma), 2'b00};
        s1_frm    <= bus.frm;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_full   <= 1'b0;
      s2_sign_l <= 1'b0;
      s2_sign_s <= 1'b0;
      s2_inv    <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_exp    <= '0;
      s2_frac_l <= '0;
      s2_frac_s <= '0;
      s2_frm    <= '0;
    end else if (s1_adv) begin
      s2_full <= s1_full;
      if (s1_full) begin
        s2_sign_l <= s1_sign_l;
        s2_sign_s <= s1_sign_s;
        s2_inv    <= s1_inv;
        s2_ovf    <= s1_ovf;
        s2_exp    <= s1_exp;
        s2_frac_l <= s1_frac_l;
        s2_frac_s <= sh_out;
        s2_frm    <= s1_frm;
      end
    end
  end

  assign bus.out_valid = s2_full;
  assign bus.sign_l    = s2_sign_l;
  assign bus.sign_s    = s2_sign_s;
  assign bus.frac_l    = s2_frac_l;
  assign bus.frac_s    = s2_frac_s;
  assign bus.exp_max   = s2_exp;
  assign bus.inv       = s2_inv;
  assign bus.ovf       = s2_ovf;
  assign bus.frm_out   = s2_frm;

endmodule

// File: tb/tb_add_align_unpack.sv
// tb/tb_add_align_unpack.sv - directed vector bench for add_align_unpack
module tb_add_align_unpack;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  add_align_unpack_if bus ();

  add_align_unpack dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [2:0]  frm;
    logic        sl, ss;
    logic [25:0] fl, fs;
    logic [7:0]  em;
    logic        inv, ovf;
    logic        cd, cs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic sub, logic [2:0] frm,
                              logic sl, logic ss, logic [25:0] fl, logic [25:0] fs,
                              logic [7:0] em, logic inv, logic ovf, logic cd, logic cs);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.frm = frm; v.sl = sl; v.ss = ss;
    v.fl = fl; v.fs = fs; v.em = em; v.inv = inv; v.ovf = ovf; v.cd = cd; v.cs = cs;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.op_a     = v.a;
    bus.op_b     = v.b;
    bus.sub      = v.sub;
    bus.frm      = v.frm;
    bus.in_valid = valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   cnt, idx, ngot, stall_bad, stale;
    logic rdy;
    logic [7:0]  got_em[3];
    logic [25:0] got_fs[3];
    int   bp[3];

    //    a             b             sub  frm  sl ss fl            fs            em     inv ovf cd cs
    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 0, 3'd0, 0, 0, 26'h2000000, 26'h2000000, 8'h7F, 0, 0, 1, 1));
    vecs.push_back(mk(32'h40000000, 32'h3F800000, 0, 3'd1, 0, 0, 26'h2000000, 26'h1000000, 8'h80, 0, 0, 1, 1));
    vecs.push_back(mk(32'h4F800000, 32'h3F800001, 0, 3'd2, 0, 0, 26'h2000000, 26'h0000001, 8'h9F, 0, 0, 1, 1));
    vecs.push_back(mk(32'h3F800000, 32'h4F800000, 1, 3'd3, 1, 0, 26'h2000000, 26'h0000001, 8'h9F, 0, 0, 1, 1));
    vecs.push_back(mk(32'h7F800000, 32'h7F800000, 1, 3'd4, 0, 0, 26'h0,       26'h0,       8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(32'h7FC00000, 32'h3F800000, 0, 3'd5, 0, 0, 26'h0,       26'h0,       8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(32'hFF800000, 32'h3F800000, 0, 3'd6, 1, 0, 26'h0,       26'h0,       8'h00, 0, 1, 0, 1));
    vecs.push_back(mk(32'h00400000, 32'h3F800000, 0, 3'd7, 0, 0, 26'h2000000, 26'h0000000, 8'h7F, 0, 0, 1, 1));
    vecs.push_back(mk(32'h3F800000, 32'hBFC00000, 0, 3'd0, 1, 0, 26'h3000000, 26'h2000000, 8'h7F, 0, 0, 1, 1));
    vecs.push_back(mk(32'h3F800001, 32'h41000000, 0, 3'd1, 0, 0, 26'h2000000, 26'h0400001, 8'h82, 0, 0, 1, 1));
    vecs.push_back(mk(32'h3FC00000, 32'h4B800000, 0, 3'd2, 0, 0, 26'h2000000, 26'h0000003, 8'h97, 0, 0, 1, 1));
    vecs.push_back(mk(32'h3FC00000, 32'h4C000000, 0, 3'd3, 0, 0, 26'h2000000, 26'h0000001, 8'h98, 0, 0, 1, 1));
    vecs.push_back(mk(32'h7F800000, 32'h7F800000, 0, 3'd4, 0, 0, 26'h0,       26'h0,       8'h00, 0, 1, 0, 1));
    vecs.push_back(mk(32'h3F800000, 32'hFF800000, 0, 3'd5, 1, 0, 26'h0,       26'h0,       8'h00, 0, 1, 0, 1));
    vecs.push_back(mk(32'h7F800000, 32'hFF800000, 0, 3'd6, 0, 0, 26'h0,       26'h0,       8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(32'h00000000, 32'h80000000, 0, 3'd7, 0, 1, 26'h0,       26'h0,       8'h00, 0, 0, 1, 1));
    vecs.push_back(mk(32'hBF800000, 32'h3F800000, 1, 3'd0, 1, 1, 26'h2000000, 26'h2000000, 8'h7F, 0, 0, 1, 1));

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0; bus.frm = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset exp_max", 32'(bus.exp_max), 32'd0);
    chk("reset frac_l", 32'(bus.frac_l), 32'd0);
    chk("reset frac_s", 32'(bus.frac_s), 32'd0);
    chk("reset flags", {30'd0, bus.inv, bus.ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i], 1'b1);
      rdy = bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d accepted", i), 32'(rdy), 32'd1);
      cnt = 1;
      while (!bus.out_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      chk($sformatf("v%0d latency", i), 32'(cnt), 32'd2);
      chk($sformatf("v%0d inv", i), 32'(bus.inv), 32'(vecs[i].inv));
      chk($sformatf("v%0d ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
      chk($sformatf("v%0d frm_out", i), 32'(bus.frm_out), 32'(vecs[i].frm));
      if (vecs[i].cs) chk($sformatf("v%0d sign_l", i), 32'(bus.sign_l), 32'(vecs[i].sl));
      if (vecs[i].cd) begin
        chk($sformatf("v%0d sign_s", i), 32'(bus.sign_s), 32'(vecs[i].ss));
        chk($sformatf("v%0d frac_l", i), 32'(bus.frac_l), 32'(vecs[i].fl));
        chk($sformatf("v%0d frac_s", i), 32'(bus.frac_s), 32'(vecs[i].fs));
        chk($sformatf("v%0d exp_max", i), 32'(bus.exp_max), 32'(vecs[i].em));
      end
    end

    // Backpressure: three offered with the sink stalled for five cycles.
    bp[0] = 0; bp[1] = 1; bp[2] = 2;
    @(negedge clk);
    bus.out_ready = 1'b0;
    idx = 0;
    stall_bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (c >= 2 && (!bus.out_valid || bus.exp_max !== vecs[bp[0]].em ||
                     bus.frac_s !== vecs[bp[0]].fs)) stall_bad++;
      drive(vecs[bp[idx < 3 ? idx : 2]], idx < 3);
      rdy = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && rdy) idx++;
      @(negedge clk);
    end
    chk("stall accepted count", 32'(idx), 32'd2);
    chk("stall in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall output held", 32'(stall_bad), 32'd0);
    bus.out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 20 && ngot < 3; c++) begin
      if (bus.out_valid) begin
        got_em[ngot] = bus.exp_max;
        got_fs[ngot] = bus.frac_s;
        ngot++;
      end
      drive(vecs[bp[idx < 3 ? idx : 2]], idx < 3);
      rdy = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && rdy) idx++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("drain count", 32'(ngot), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain%0d exp_max", k), 32'(got_em[k]), 32'(vecs[bp[k]].em));
      chk($sformatf("drain%0d frac_s", k), 32'(got_fs[k]), 32'(vecs[bp[k]].fs));
    end
    @(negedge clk);
    chk("drain empty", 32'(bus.out_valid), 32'd0);

    // Reset with two transactions in flight.
    drive(vecs[1], 1'b1);
    @(negedge clk);
    drive(vecs[2], 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre-reset out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("reset flush out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("no stale result", 32'(stale), 32'd0);
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
